// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the arithmetic_unit control sequencer.
// Holds the state encoding, the operation codes and the datapath width.
package alu_ctrl_pkg;

    localparam int WIDTH = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_Q,
        LOAD_M,
        CLR,
        M_EVAL,
        M_SHIFT,
        D_SHIFT,
        D_SUB,
        D_FIX,
        DONE
    } state_t;

    // Multiply and divide need the iterative A/Q sequence; add and sub finish after loading.
    function automatic logic isIterative(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_control_unit.sv
// Control sequencer for the 8-bit arithmetic_unit: operand fetch, then add/sub,
// Booth multiply or restoring divide, driving c0..c10 from state plus datapath status.
module alu_control_unit
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = alu_ctrl_pkg::WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op_i,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       cnt_done,
    input  logic       q0,
    input  logic       qm1,
    input  logic       a_msb,
    output logic [1:0] op_o,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       c5,
    output logic       c6,
    output logic       c7,
    output logic       c8,
    output logic       c9,
    output logic       c10,
    output logic       busy,
    output logic       done
);

    localparam int ITER_BITS = $clog2(WIDTH);
    localparam logic [ITER_BITS-1:0] LAST_ITER = ITER_BITS'(WIDTH - 1);

    state_t               state_q;
    logic [ITER_BITS-1:0] iter_q;
    logic [1:0]           op_q;

    // State, iteration count and latched op; start is only honoured in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            op_q    <= OP_ADD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= op_i;
                        state_q <= LOAD_Q;
                    end
                end
                LOAD_Q: begin
                    if (in_valid) begin
                        state_q <= LOAD_M;
                    end
                end
                LOAD_M: begin
                    if (in_valid) begin
                        state_q <= isIterative(op_q) ? CLR : DONE;
                    end
                end
                CLR: begin
                    iter_q  <= '0;
                    state_q <= (op_q == OP_DIV) ? D_SHIFT : M_EVAL;
                end
                M_EVAL: begin
                    state_q <= M_SHIFT;
                end
                M_SHIFT: begin
                    if (iter_q == LAST_ITER) begin
                        state_q <= DONE;
                    end else begin
                        iter_q  <= iter_q + 1'b1;
                        state_q <= M_EVAL;
                    end
                end
                D_SHIFT: begin
                    state_q <= D_SUB;
                end
                D_SUB: begin
                    state_q <= D_FIX;
                end
                D_FIX: begin
                    if (iter_q == LAST_ITER) begin
                        state_q <= DONE;
                    end else begin
                        iter_q  <= iter_q + 1'b1;
                        state_q <= D_SHIFT;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Control decode; the datapath counter saturates, so c5 is dropped once it reads 7.
    always_comb begin
        in_ready = 1'b0;
        busy     = (state_q != IDLE);
        done     = 1'b0;
        c0 = 1'b0;
        c1 = 1'b0;
        c2 = 1'b0;
        c3 = 1'b0;
        c4 = 1'b0;
        c5 = 1'b0;
        c6 = 1'b0;
        c7 = 1'b0;
        c8 = 1'b0;
        case (state_q)
            LOAD_Q: begin
                in_ready = 1'b1;
                c0       = in_valid;
            end
            LOAD_M: begin
                in_ready = 1'b1;
                c1       = in_valid;
            end
            CLR: begin
                c7 = 1'b1;
            end
            M_EVAL: begin
                if (q0 != qm1) begin
                    c2 = 1'b1;
                    c3 = q0;
                end
            end
            M_SHIFT: begin
                c4 = 1'b1;
                c5 = ~cnt_done;
                c6 = a_msb;
            end
            D_SHIFT: begin
                c4 = 1'b1;
                c5 = ~cnt_done;
                c6 = 1'b0;
            end
            D_SUB: begin
                c2 = 1'b1;
                c3 = 1'b1;
            end
            D_FIX: begin
                if (a_msb) begin
                    c2 = 1'b1;
                end else begin
                    c8 = 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign op_o = op_q;
    assign c9   = 1'b0;
    assign c10  = 1'b0;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit, closing the loop through a small behavioural
// model of the 8-bit arithmetic_unit so results can be read on z.
module tb_alu_control_unit;
    import alu_ctrl_pkg::*;

    localparam int MAX_CYC = 60;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] op_i;
    logic       in_valid;
    logic       in_ready;
    logic       cnt_done;
    logic       q0;
    logic       qm1;
    logic       a_msb;
    logic [1:0] op_o;
    logic       c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10;
    logic       busy;
    logic       done;

    logic [7:0]  inBus;
    logic [7:0]  regA, regQ, regM;
    logic        regQm1;
    logic [2:0]  cnt;
    logic [7:0]  sumQM;
    logic [15:0] z;
    logic [10:0] ctrlVec;

    int testsRun;
    int testsFailed;

    typedef struct {
        int doneCyc;
        int readyFirst;
        int readyCnt;
        int busyCnt;
        int c0Cnt;
        int c1Cnt;
        int c2Cnt;
        int c3Cnt;
        int c4Cnt;
        int c5Cnt;
        int c8Cnt;
        logic [15:0] zDone;
    } opRes_t;

    alu_control_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_i     (op_i),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cnt_done (cnt_done),
        .q0       (q0),
        .qm1      (qm1),
        .a_msb    (a_msb),
        .op_o     (op_o),
        .c0       (c0),
        .c1       (c1),
        .c2       (c2),
        .c3       (c3),
        .c4       (c4),
        .c5       (c5),
        .c6       (c6),
        .c7       (c7),
        .c8       (c8),
        .c9       (c9),
        .c10      (c10),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: right shift of {A,Q,Qm1} for multiply, left shift of {A,Q} for divide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regA   <= 8'h00;
            regQ   <= 8'h00;
            regM   <= 8'h00;
            regQm1 <= 1'b0;
            cnt    <= 3'd0;
        end else begin
            if (c0) regQ <= inBus;
            if (c1) regM <= inBus;
            if (c7) begin
                regA   <= 8'h00;
                regQm1 <= 1'b0;
            end
            if (c2) regA <= c3 ? (regA - regM) : (regA + regM);
            if (c4) begin
                if (op_o == OP_DIV) {regA, regQ} <= {regA[6:0], regQ, c6};
                else {regA, regQ, regQm1} <= {c6, regA, regQ};
            end
            if (c8) regQ[0] <= 1'b1;
            if (c5 && cnt != 3'd7) cnt <= cnt + 3'd1;
        end
    end

    assign q0       = regQ[0];
    assign qm1      = regQm1;
    assign a_msb    = regA[7];
    assign cnt_done = (cnt == 3'd7);
    assign sumQM    = op_o[0] ? (regQ - regM) : (regQ + regM);
    assign z        = op_o[1] ? {regA, regQ} : {{8{sumQM[7]}}, sumQM};
    assign ctrlVec  = {c10, c9, c8, c7, c6, c5, c4, c3, c2, c1, c0};

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doReset();
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        inBus    = 8'h00;
        op_i     = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from IDLE, holding off in_valid for the requested number of
    // LOAD_Q/LOAD_M cycles; midStart >= 0 pulses start with a different op mid-run.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] opA, input logic [7:0] opB,
                                 input int stallQ, input int stallM, input int midStart,
                                 output opRes_t r);
        int qWait;
        int mWait;
        bit gotQ;
        bit seenDone;
        qWait = 0;
        mWait = 0;
        gotQ = 1'b0;
        seenDone = 1'b0;
        r = '{doneCyc: -1, readyFirst: -1, readyCnt: 0, busyCnt: 0, c0Cnt: 0, c1Cnt: 0,
              c2Cnt: 0, c3Cnt: 0, c4Cnt: 0, c5Cnt: 0, c8Cnt: 0, zDone: 16'hxxxx};
        for (int cyc = 0; cyc <= MAX_CYC && !seenDone; cyc++) begin
            start = (cyc == 0) || (cyc == midStart);
            op_i  = (cyc == 0) ? op : ~op;
            if (in_ready && !gotQ) begin
                in_valid = (qWait >= stallQ);
                qWait++;
            end else if (in_ready) begin
                in_valid = (mWait >= stallM);
                mWait++;
            end else begin
                in_valid = 1'b1;
            end
            inBus = gotQ ? opB : opA;
            #1;
            if (in_ready) begin
                r.readyCnt++;
                if (r.readyFirst < 0) r.readyFirst = cyc;
            end
            if (busy) r.busyCnt++;
            if (c0) r.c0Cnt++;
            if (c1) r.c1Cnt++;
            if (c2) r.c2Cnt++;
            if (c3) r.c3Cnt++;
            if (c4) r.c4Cnt++;
            if (c5) r.c5Cnt++;
            if (c8) r.c8Cnt++;
            if (done) begin
                seenDone = 1'b1;
                r.doneCyc = cyc;
                r.zDone = z;
            end
            if (in_ready && in_valid && !gotQ) gotQ = 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        inBus    = 8'h00;
        op_i     = 2'b00;
        #1;
        testsRun++;
        if ({in_ready, busy, done, op_o, ctrlVec} !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %h expected 0000", {in_ready, busy, done, op_o, ctrlVec});
        end
        doReset();
        testsRun++;
        if ({in_ready, busy, done, op_o, ctrlVec} !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL idle_after_reset: got %h expected 0000", {in_ready, busy, done, op_o, ctrlVec});
        end
    endtask

    task automatic test_add();
        opRes_t r;
        doReset();
        applyStimulus(OP_ADD, 8'h05, 8'h03, 0, 0, -1, r);
        testsRun++;
        if (r.doneCyc !== 3) begin
            testsFailed++;
            $display("[TB] FAIL add_done_cycle: got %0d expected 3", r.doneCyc);
        end
        testsRun++;
        if (r.readyFirst !== 1 || r.readyCnt !== 2) begin
            testsFailed++;
            $display("[TB] FAIL add_in_ready: first %0d count %0d expected first 1 count 2", r.readyFirst, r.readyCnt);
        end
        testsRun++;
        if (r.busyCnt !== 3) begin
            testsFailed++;
            $display("[TB] FAIL add_busy_cycles: got %0d expected 3", r.busyCnt);
        end
        testsRun++;
        if (r.zDone !== 16'h0008) begin
            testsFailed++;
            $display("[TB] FAIL add_z: got %h expected 0008", r.zDone);
        end
        testsRun++;
        if (z !== 16'h0008 || done !== 1'b0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL add_idle_hold: z %h done %b busy %b expected 0008 0 0", z, done, busy);
        end
    endtask

    task automatic test_sub();
        opRes_t r;
        doReset();
        applyStimulus(OP_SUB, 8'h03, 8'h05, 0, 0, -1, r);
        testsRun++;
        if (r.zDone !== 16'hFFFE || r.doneCyc !== 3) begin
            testsFailed++;
            $display("[TB] FAIL sub_result: z %h at cycle %0d expected FFFE at 3", r.zDone, r.doneCyc);
        end
        testsRun++;
        if (r.c3Cnt !== 0) begin
            testsFailed++;
            $display("[TB] FAIL sub_c3_quiet: got %0d c3 cycles expected 0", r.c3Cnt);
        end
    endtask

    task automatic test_mul();
        opRes_t r;
        doReset();
        applyStimulus(OP_MUL, 8'h07, 8'hFD, 0, 0, -1, r);
        testsRun++;
        if (r.doneCyc !== 20) begin
            testsFailed++;
            $display("[TB] FAIL mul_done_cycle: got %0d expected 20", r.doneCyc);
        end
        testsRun++;
        if (r.c4Cnt !== 8 || r.c5Cnt !== 7) begin
            testsFailed++;
            $display("[TB] FAIL mul_shifts: c4 %0d c5 %0d expected 8 and 7", r.c4Cnt, r.c5Cnt);
        end
        testsRun++;
        if (r.c2Cnt !== 2 || r.c3Cnt !== 1) begin
            testsFailed++;
            $display("[TB] FAIL mul_booth_ops: c2 %0d c3 %0d expected 2 and 1", r.c2Cnt, r.c3Cnt);
        end
        testsRun++;
        if (r.zDone !== 16'hFFEB) begin
            testsFailed++;
            $display("[TB] FAIL mul_z: got %h expected FFEB", r.zDone);
        end
    endtask

    task automatic test_div();
        opRes_t r;
        doReset();
        applyStimulus(OP_DIV, 8'h64, 8'h07, 0, 0, -1, r);
        testsRun++;
        if (r.doneCyc !== 28) begin
            testsFailed++;
            $display("[TB] FAIL div_done_cycle: got %0d expected 28", r.doneCyc);
        end
        testsRun++;
        if (r.zDone !== 16'h020E) begin
            testsFailed++;
            $display("[TB] FAIL div_z: got %h expected 020E", r.zDone);
        end
        testsRun++;
        if (r.c2Cnt !== 13 || r.c3Cnt !== 8 || r.c8Cnt !== 3 || r.c4Cnt !== 8) begin
            testsFailed++;
            $display("[TB] FAIL div_controls: c2 %0d c3 %0d c8 %0d c4 %0d expected 13 8 3 8",
                     r.c2Cnt, r.c3Cnt, r.c8Cnt, r.c4Cnt);
        end
    endtask

    task automatic test_div_by_zero();
        opRes_t r;
        doReset();
        applyStimulus(OP_DIV, 8'h2A, 8'h00, 0, 0, -1, r);
        testsRun++;
        if (r.zDone !== 16'h2AFF || r.doneCyc !== 28) begin
            testsFailed++;
            $display("[TB] FAIL div_by_zero: z %h at cycle %0d expected 2AFF at 28", r.zDone, r.doneCyc);
        end
    endtask

    task automatic test_in_valid_stall();
        opRes_t r;
        doReset();
        applyStimulus(OP_ADD, 8'h05, 8'h03, 4, 4, -1, r);
        testsRun++;
        if (r.doneCyc !== 11) begin
            testsFailed++;
            $display("[TB] FAIL stall_done_cycle: got %0d expected 11", r.doneCyc);
        end
        testsRun++;
        if (r.c0Cnt !== 1 || r.c1Cnt !== 1 || r.readyCnt !== 10) begin
            testsFailed++;
            $display("[TB] FAIL stall_load_pulses: c0 %0d c1 %0d ready %0d expected 1 1 10",
                     r.c0Cnt, r.c1Cnt, r.readyCnt);
        end
        testsRun++;
        if (r.zDone !== 16'h0008) begin
            testsFailed++;
            $display("[TB] FAIL stall_z: got %h expected 0008", r.zDone);
        end
    endtask

    task automatic test_reset_abort();
        opRes_t r;
        doReset();
        op_i     = OP_MUL;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 11; cyc++) begin
            start = (cyc == 0);
            inBus = (cyc <= 1) ? 8'h07 : 8'hFD;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        testsRun++;
        if ({c4, c5} !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL abort_in_shift: c4c5 %b expected 11", {c4, c5});
        end
        rst = 1'b1;
        #1;
        testsRun++;
        if ({in_ready, busy, done, op_o, ctrlVec} !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL abort_outputs: got %h expected 0000", {in_ready, busy, done, op_o, ctrlVec});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(OP_MUL, 8'h02, 8'h03, 0, 0, 6, r);
        testsRun++;
        if (r.zDone !== 16'h0006 || r.doneCyc !== 20) begin
            testsFailed++;
            $display("[TB] FAIL abort_new_mul: z %h at cycle %0d expected 0006 at 20", r.zDone, r.doneCyc);
        end
        testsRun++;
        if (op_o !== OP_MUL || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_ignored_start: op_o %b busy %b expected 10 0", op_o, busy);
        end
    endtask

    task automatic test_back_to_back();
        opRes_t r;
        doReset();
        applyStimulus(OP_ADD, 8'h10, 8'h20, 0, 0, -1, r);
        applyStimulus(OP_SUB, 8'h10, 8'h20, 0, 0, -1, r);
        testsRun++;
        if (r.zDone !== 16'hFFF0 || r.doneCyc !== 3 || op_o !== OP_SUB) begin
            testsFailed++;
            $display("[TB] FAIL b2b_sub: z %h cycle %0d op_o %b expected FFF0 3 01", r.zDone, r.doneCyc, op_o);
        end
        applyStimulus(OP_MUL, 8'h02, 8'h03, 0, 0, -1, r);
        testsRun++;
        if (r.zDone !== 16'h0006 || r.c5Cnt !== 7) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first_mul: z %h c5 %0d expected 0006 7", r.zDone, r.c5Cnt);
        end
        applyStimulus(OP_MUL, 8'hFF, 8'hFF, 0, 0, -1, r);
        testsRun++;
        if (r.zDone !== 16'h0001 || r.c5Cnt !== 0 || r.doneCyc !== 20) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second_mul: z %h c5 %0d cycle %0d expected 0001 0 20",
                     r.zDone, r.c5Cnt, r.doneCyc);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_div_by_zero();
        test_in_valid_stall();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
